// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package fifo_pkg;

    // Read-mode selectors for the FWFT parameter
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Default threshold settings: almost_empty at <= 2 entries,
    // almost_full at DEPTH-2 entries or more
    localparam int DEF_AE_LEVEL  = 2;
    localparam int DEF_AF_MARGIN = 2;

    // Address width needed to index DEPTH entries (at least 1 bit)
    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage array for sync_fifo_param: one write port and one
// read port, with the read side either combinational or registered.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int REG_READ   = 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic                  rclr,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH) - 1];

    // Write port; contents are never cleared
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    if (REG_READ != 0) begin : g_reg_read
        // Registered read: holds unless a read is requested; old data is
        // returned when the same address is written in the same cycle
        always_ff @(posedge clk) begin
            if (rclr) begin
                rdata <= '0;
            end else if (re) begin
                rdata <= mem[raddr];
            end
        end
    end else begin : g_comb_read
        logic unused_ctrl;
        assign unused_ctrl = re ^ rclr;
        assign rdata       = mem[raddr];
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with selectable registered or
// first-word-fall-through read, threshold flags, occupancy count, sticky
// error flags and synchronous flush.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = FIFO_MODE_STD,
    parameter int AF_LEVEL   = DEPTH - DEF_AF_MARGIN,
    parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    w_en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    r_en,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH=%0d must be a power of two >= 2", DEPTH);
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
        $error("sync_fifo_param: AF_LEVEL=%0d outside 1..DEPTH", AF_LEVEL);
    end
    if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
        $error("sync_fifo_param: AE_LEVEL=%0d outside 0..DEPTH-1", AE_LEVEL);
    end
    if ((FWFT != FIFO_MODE_STD) && (FWFT != FIFO_MODE_FWFT)) begin : g_bad_mode
        $error("sync_fifo_param: FWFT=%0d must be 0 or 1", FWFT);
    end

    // Pointers carry one extra wrap bit above the address
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [CW-1:0] wr_ptr_nx;
    logic [CW-1:0] rd_ptr_nx;
    logic [CW-1:0] count_nx;

    logic rd_acc;
    logic wr_acc;
    logic full_nx;
    logic empty_nx;
    logic af_nx;
    logic ae_nx;
    logic ovf_nx;
    logic udf_nx;

    logic                  mem_we;
    logic                  mem_re;
    logic                  mem_clr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Accept decisions and next-state values for every status output
    always_comb begin
        rd_acc    = r_en & ~empty;
        // A write to a full FIFO succeeds only when a pop frees the slot
        wr_acc    = w_en & (~full | rd_acc);
        wr_ptr_nx = wr_ptr + CW'(wr_acc);
        rd_ptr_nx = rd_ptr + CW'(rd_acc);
        count_nx  = count + CW'(wr_acc) - CW'(rd_acc);
        full_nx   = (wr_ptr_nx[PW-1:0] == rd_ptr_nx[PW-1:0]) &&
                    (wr_ptr_nx[PW] != rd_ptr_nx[PW]);
        empty_nx  = (wr_ptr_nx == rd_ptr_nx);
        af_nx     = (count_nx >= CW'(AF_LEVEL));
        ae_nx     = (count_nx <= CW'(AE_LEVEL));
        ovf_nx    = overflow | (w_en & ~wr_acc);
        udf_nx    = underflow | (r_en & empty);
    end

    // Memory strobes: requests in a reset or flush cycle are dropped
    always_comb begin
        mem_clr = rst | flush;
        mem_we  = wr_acc & ~mem_clr;
        mem_re  = rd_acc & ~mem_clr;
    end

    // Control state; reset and flush clear identically, rst taking precedence
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nx;
            rd_ptr       <= rd_ptr_nx;
            count        <= count_nx;
            full         <= full_nx;
            empty        <= empty_nx;
            almost_full  <= af_nx;
            almost_empty <= ae_nx;
            overflow     <= ovf_nx;
            underflow    <= udf_nx;
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (PW),
        .REG_READ   ((FWFT == FIFO_MODE_STD) ? 1 : 0)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr[PW-1:0]),
        .wdata (data_in),
        .re    (mem_re),
        .rclr  (mem_clr),
        .raddr (rd_ptr[PW-1:0]),
        .rdata (ram_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft_out
        // Head entry shown directly; forced to zero while nothing is stored
        assign data_out = empty ? '0 : ram_rdata;
    end else begin : g_std_out
        assign data_out = ram_rdata;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench: six FIFOs (DEPTH 16/4/64, both read modes) share one
// stimulus stream; a queue-based reference model predicts every output.
`timescale 1ns/1ps
module tb_sync_fifo_param;

    localparam int NI = 6;

    function automatic int dep_of(input int g);
        case (g / 2)
            0:       return 16;
            1:       return 4;
            default: return 64;
        endcase
    endfunction

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic [7:0] data_in = 8'h00;

    always #5 clk = ~clk;

    logic [7:0]    dout_a [NI];
    logic [7:0]    cnt_a  [NI];
    logic [NI-1:0] full_a, empty_a, af_a, ae_a, ovf_a, udf_a;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int D = dep_of(g);
        logic [$clog2(D):0] c;
        logic [7:0]         dq;
        sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(D), .FWFT(g % 2)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .flush        (flush),
            .w_en         (w_en),
            .data_in      (data_in),
            .r_en         (r_en),
            .data_out     (dq),
            .full         (full_a[g]),
            .empty        (empty_a[g]),
            .almost_full  (af_a[g]),
            .almost_empty (ae_a[g]),
            .count        (c),
            .overflow     (ovf_a[g]),
            .underflow    (udf_a[g])
        );
        assign cnt_a[g]  = 8'(c);
        assign dout_a[g] = dq;
    end

    typedef struct packed {
        logic [NI-1:0][7:0] cnt;
        logic [NI-1:0][7:0] dat;
        logic [NI-1:0]      dchk;
        logic [NI-1:0]      full;
        logic [NI-1:0]      empty;
        logic [NI-1:0]      af;
        logic [NI-1:0]      ae;
        logic [NI-1:0]      ovf;
        logic [NI-1:0]      udf;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] mq[NI][$];
    logic [7:0] last_d[NI];
    bit         m_ovf[NI];
    bit         m_udf[NI];
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         stim_done = 0;

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s inst%0d (depth %0d fwft %0d) t=%0t actual=%0h required=%0h",
                     nm, g, dep_of(g), g % 2, $time, act, req);
        end
    endtask

    // Drive one cycle of stimulus and push the predicted post-edge outputs
    task automatic step(input bit w, input bit r, input bit f, input bit rs, input logic [7:0] d);
        exp_t e;
        int   dd;
        int   sz;
        bit   emp, ful, racc, wacc;
        logic [7:0] x;
        e = '0;
        @(negedge clk);
        w_en = w; r_en = r; flush = f; rst = rs; data_in = d;
        for (int g = 0; g < NI; g++) begin
            dd  = dep_of(g);
            emp = (mq[g].size() == 0);
            ful = (mq[g].size() == dd);
            if (rs || f) begin
                mq[g].delete();
                m_ovf[g]  = 0;
                m_udf[g]  = 0;
                last_d[g] = 8'h00;
            end else begin
                racc = r && !emp;
                wacc = w && (!ful || racc);
                if (w && !wacc) m_ovf[g] = 1;
                if (r && emp)   m_udf[g] = 1;
                if (racc) begin
                    x = mq[g].pop_front();
                    if (g % 2 == 0) last_d[g] = x;
                end
                if (wacc) mq[g].push_back(d);
            end
            sz         = mq[g].size();
            e.cnt[g]   = 8'(sz);
            e.full[g]  = (sz == dd);
            e.empty[g] = (sz == 0);
            e.af[g]    = (sz >= dd - 2);
            e.ae[g]    = (sz <= 2);
            e.ovf[g]   = m_ovf[g];
            e.udf[g]   = m_udf[g];
            if (g % 2 == 0) begin
                e.dchk[g] = 1'b1;
                e.dat[g]  = last_d[g];
            end else begin
                e.dchk[g] = (sz != 0);
                e.dat[g]  = (sz != 0) ? mq[g][0] : 8'h00;
            end
        end
        expq.push_back(e);
    endtask

    // Monitor: after each rising edge, compare every DUT against its prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                for (int g = 0; g < NI; g++) begin
                    chk("count",        g, 32'(cnt_a[g]),   32'(e.cnt[g]));
                    chk("full",         g, 32'(full_a[g]),  32'(e.full[g]));
                    chk("empty",        g, 32'(empty_a[g]), 32'(e.empty[g]));
                    chk("almost_full",  g, 32'(af_a[g]),    32'(e.af[g]));
                    chk("almost_empty", g, 32'(ae_a[g]),    32'(e.ae[g]));
                    chk("overflow",     g, 32'(ovf_a[g]),   32'(e.ovf[g]));
                    chk("underflow",    g, 32'(udf_a[g]),   32'(e.udf[g]));
                    if (e.dchk[g]) chk("data_out", g, 32'(dout_a[g]), 32'(e.dat[g]));
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int pw;
        for (int g = 0; g < NI; g++) begin
            last_d[g] = 8'h00;
            m_ovf[g]  = 0;
            m_udf[g]  = 0;
        end
        // Reset state
        step(0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 1, 8'h00);
        // Fill with 0x00..0x0F, then one write too many
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'(i));
        step(1, 0, 0, 0, 8'hEE);
        // Drain, then one read too many
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        // Single word: fall-through visible with no read, then popped
        step(0, 0, 1, 0, 8'h00);
        step(1, 0, 0, 0, 8'hA5);
        step(0, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        // Simultaneous read and write while full, across pointer wrap
        step(0, 0, 1, 0, 8'h00);
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'($urandom));
        for (int i = 0; i < 40; i++) step(1, 1, 0, 0, 8'($urandom));
        // Flush with count=7 while also requesting write and read
        step(0, 0, 1, 0, 8'h00);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 8'(8'h10 + i));
        step(1, 1, 1, 0, 8'h77);
        step(0, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h31);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'h00);
        // Random mix in phases of varying write/read bias
        for (int ph = 0; ph < 40; ph++) begin
            pw = $urandom_range(90, 10);
            for (int i = 0; i < 250; i++) begin
                step(($urandom_range(99) < pw), ($urandom_range(99) < (100 - pw + 5)),
                     ($urandom_range(999) == 0), ($urandom_range(4999) == 0), 8'($urandom));
            end
        end
        step(0, 0, 0, 0, 8'h00);
        repeat (3) @(posedge clk);
        #5;
        n_cmp++;
        if (expq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", expq.size());
        end
        stim_done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
